// File: rtl/core_loader.sv
// Boot sequencer: holds the RV32 core in reset, streams a length-prefixed program
// image into instruction memory word-by-word, then releases reset and pulses start.
module core_loader #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rstn,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_REL   = 3'd4,
        ST_START = 3'd5,
        ST_RUN   = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        byte_cnt_r;
    logic [31:0]       len_r;
    logic [31:0]       word_idx_r;
    logic [31:0]       word_buf_r;
    logic              accept_s;
    logic              last_byte_s;
    logic              restart_s;
    logic [31:0]       len_next_s;
    logic [31:0]       word_next_s;
    logic [ADDR_W-1:0] addr_s;

    assign accept_s    = rx_valid && rx_ready;
    assign last_byte_s = accept_s && (byte_cnt_r == 2'd3);
    assign restart_s   = load_req && ((state_r == ST_IDLE) || (state_r == ST_RUN) || (state_r == ST_ERR));
    // Both header and payload arrive little-endian, so new bytes shift in from the top.
    assign len_next_s  = {rx_data, len_r[31:8]};
    assign word_next_s = {rx_data, word_buf_r[31:8]};
    assign addr_s      = ADDR_W'(BASE_ADDR) + ADDR_W'({word_idx_r, 2'b00});

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (load_req) state_s = ST_HDR;
                else          state_s = state_r;
            end
            ST_HDR: begin
                if (last_byte_s) begin
                    if ((len_next_s == 32'd0) || (len_next_s > 32'(MAX_WORDS))) state_s = ST_ERR;
                    else                                                      state_s = ST_DATA;
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (last_byte_s) state_s = ST_WRITE;
                else             state_s = ST_DATA;
            end
            ST_WRITE: begin
                if (word_idx_r == (len_r - 32'd1)) state_s = ST_REL;
                else                               state_s = ST_DATA;
            end
            ST_REL:   state_s = ST_START;
            ST_START: state_s = ST_RUN;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Status outputs registered from the next state so they line up with state_r
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_ready  <= 1'b0;
            imem_we   <= 1'b0;
            core_rstn <= 1'b0;
            start     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rx_ready  <= (state_s == ST_HDR) || (state_s == ST_DATA);
            imem_we   <= (state_s == ST_WRITE);
            core_rstn <= (state_s == ST_REL) || (state_s == ST_START) || (state_s == ST_RUN);
            start     <= (state_s == ST_START);
            busy      <= (state_s == ST_HDR) || (state_s == ST_DATA) || (state_s == ST_WRITE) ||
                         (state_s == ST_REL) || (state_s == ST_START);
            done      <= (state_s == ST_RUN);
            err       <= (state_s == ST_ERR);
        end
    end

    // Byte counter, header length, word index and payload shift buffer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt_r <= 2'd0;
            len_r      <= 32'd0;
            word_idx_r <= 32'd0;
            word_buf_r <= 32'd0;
        end else if (restart_s) begin
            byte_cnt_r <= 2'd0;
            len_r      <= 32'd0;
            word_idx_r <= 32'd0;
        end else if (accept_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (state_r == ST_HDR) len_r      <= len_next_s;
            else                   word_buf_r <= word_next_s;
        end else if (state_r == ST_WRITE) begin
            word_idx_r <= word_idx_r + 32'd1;
        end
    end

    // Write port captured on the last byte of a word; it holds between writes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            imem_waddr <= '0;
            imem_wdata <= 32'd0;
        end else if ((state_r == ST_DATA) && last_byte_s) begin
            imem_waddr <= addr_s;
            imem_wdata <= word_next_s;
        end
    end

endmodule

// File: tb/tb_core_loader.sv
// Self-checking bench for core_loader: table-driven image loads on a default
// instance, plus reset-abort and small-MAX_WORDS/offset-base sequences.
module tb_core_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        lr, rxv;
    logic [7:0]  rxd;
    int          sel;
    int          errors = 0;
    int          checks = 0;
    int          start_cnt = 0;

    logic        lr0, rxv0, lr1, rxv1;
    logic        rdy0, we0, crst0, start0, busy0, done0, err0;
    logic        rdy1, we1, crst1, start1, busy1, done1, err1;
    logic [31:0] waddr0, wdata0, waddr1, wdata1;
    logic        c_rdy, c_we, c_crst, c_start, c_busy, c_done, c_err;
    logic [31:0] c_waddr, c_wdata;

    assign lr0  = (sel == 0) && lr;
    assign rxv0 = (sel == 0) && rxv;
    assign lr1  = (sel == 1) && lr;
    assign rxv1 = (sel == 1) && rxv;

    core_loader dut0 (
        .clk(clk), .rstn(rstn), .load_req(lr0), .rx_valid(rxv0), .rx_data(rxd),
        .rx_ready(rdy0), .imem_we(we0), .imem_waddr(waddr0), .imem_wdata(wdata0),
        .core_rstn(crst0), .start(start0), .busy(busy0), .done(done0), .err(err0)
    );

    core_loader #(.ADDR_W(32), .BASE_ADDR(32'h0000_1000), .MAX_WORDS(4)) dut1 (
        .clk(clk), .rstn(rstn), .load_req(lr1), .rx_valid(rxv1), .rx_data(rxd),
        .rx_ready(rdy1), .imem_we(we1), .imem_waddr(waddr1), .imem_wdata(wdata1),
        .core_rstn(crst1), .start(start1), .busy(busy1), .done(done1), .err(err1)
    );

    always_comb begin
        if (sel == 0) begin
            {c_rdy, c_we, c_crst, c_start, c_busy, c_done, c_err} = {rdy0, we0, crst0, start0, busy0, done0, err0};
            c_waddr = waddr0;
            c_wdata = wdata0;
        end else begin
            {c_rdy, c_we, c_crst, c_start, c_busy, c_done, c_err} = {rdy1, we1, crst1, start1, busy1, done1, err1};
            c_waddr = waddr1;
            c_wdata = wdata1;
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t sb_q[$];

    typedef struct {
        logic [31:0]       len;
        logic [3:0][31:0]  words;
        int                gap;
        logic              exp_err;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every write strobe pops the oldest expected write
    always @(negedge clk) begin : mon
        wr_t e;
        if (rstn && c_we) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", 64'(c_waddr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("waddr", 64'(c_waddr), 64'(e.a));
                chk("wdata", 64'(c_wdata), 64'(e.d));
            end
            chk("rx_ready_in_write", 64'(c_rdy), 64'd0);
        end
        if (rstn && c_start) start_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        int n;
        g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        for (int k = 0; k < g; k++) begin
            rxv = 1'b0;
            @(negedge clk);
        end
        rxv = 1'b1;
        rxd = b;
        n = 0;
        while (!c_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rx_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        rxv = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    // load_req with a junk byte presented alongside; the byte must not be consumed
    task automatic do_load_req();
        lr  = 1'b1;
        rxv = 1'b1;
        rxd = 8'hFF;
        @(negedge clk);
        lr  = 1'b0;
        rxv = 1'b0;
    endtask

    task automatic load_image(input logic [31:0] len, input logic [3:0][31:0] words, input int gap,
                              input logic [31:0] base, input logic exp_err, input string tag);
        do_load_req();
        chk({tag, "_hdr_state"}, 64'({c_crst, c_busy, c_rdy, c_err, c_done}), 64'(5'b01100));
        send_word(len, gap);
        if (exp_err) begin
            chk({tag, "_err_state"}, 64'({c_crst, c_busy, c_rdy, c_err, c_done, c_start}), 64'(6'b000100));
            repeat (3) @(negedge clk);
            chk({tag, "_err_hold"}, 64'({c_err, c_crst}), 64'(2'b10));
        end else begin
            for (int w = 0; w < int'(len); w++) sb_q.push_back('{a: base + 32'(4 * w), d: words[w]});
            for (int w = 0; w < int'(len); w++) send_word(words[w], gap);
            @(negedge clk);
            chk({tag, "_rel"}, 64'({c_crst, c_start, c_done, c_busy}), 64'(4'b1001));
            @(negedge clk);
            chk({tag, "_start"}, 64'({c_crst, c_start, c_done, c_busy}), 64'(4'b1101));
            @(negedge clk);
            chk({tag, "_run"}, 64'({c_crst, c_start, c_done, c_busy}), 64'(4'b1010));
            chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
            @(negedge clk);
            chk({tag, "_run_hold"}, 64'({c_crst, c_start, c_done, c_err}), 64'(4'b1010));
        end
    endtask

    initial begin
        logic [3:0][31:0] ws;
        rstn = 1'b0;
        lr   = 1'b0;
        rxv  = 1'b0;
        rxd  = 8'h00;
        sel  = 0;

        vecs[0] = '{len: 32'd2,    words: {32'h0, 32'h0, 32'h0000006F, 32'h00100513}, gap: 0, exp_err: 1'b0};
        vecs[1] = '{len: 32'd0,    words: '0,                                          gap: 0, exp_err: 1'b1};
        vecs[2] = '{len: 32'd1025, words: '0,                                          gap: 0, exp_err: 1'b1};
        vecs[3] = '{len: 32'd1,    words: {32'h0, 32'h0, 32'h0, 32'h12345678},        gap: 0, exp_err: 1'b0};
        vecs[4] = '{len: 32'd4,    words: {32'h0F0F0F0F, 32'hA5A5A5A5, 32'h0000006F, 32'h00100513}, gap: 5, exp_err: 1'b0};
        vecs[5] = '{len: 32'd1,    words: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},        gap: 0, exp_err: 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_flags", 64'({c_rdy, c_we, c_crst, c_start, c_busy, c_done, c_err}), 64'd0);
        chk("reset_bus", {c_waddr, c_wdata}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            load_image(vecs[i].len, vecs[i].words, vecs[i].gap, 32'h0, vecs[i].exp_err, $sformatf("v%0d", i));

        // Reset mid-payload of an L=3 image, after six payload bytes
        do_load_req();
        send_word(32'd3, 0);
        sb_q.push_back('{a: 32'h0, d: 32'h11223344});
        send_word(32'h11223344, 0);
        send_byte(8'h66, 0);
        send_byte(8'h77, 0);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_flags", 64'({c_rdy, c_we, c_crst, c_start, c_busy, c_done, c_err}), 64'd0);
        chk("async_reset_bus", {c_waddr, c_wdata}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        rxv  = 1'b1;
        rxd  = 8'h55;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("idle_ignores_rx", 64'({c_rdy, c_busy, c_crst}), 64'd0);
        end
        rxv = 1'b0;
        chk("reset_sb_empty", 64'(sb_q.size()), 64'd0);
        ws = {32'h0, 32'h0, 32'h0, 32'hCAFEF00D};
        load_image(32'd1, ws, 0, 32'h0, 1'b0, "post_reset");

        // Offset base with MAX_WORDS=4: L==MAX accepted, L==MAX+1 rejected
        sel = 1;
        @(negedge clk);
        ws = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        load_image(32'd4, ws, 2, 32'h0000_1000, 1'b0, "d1_max");
        load_image(32'd5, ws, 0, 32'h0000_1000, 1'b1, "d1_over");

        chk("start_pulses", 64'(start_cnt), 64'd6);
        chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_loader.md
Name: core_loader

Overview:
- Boot sequencer for the RV32 core.
- Holds the core in reset, receives a program image as a byte stream, writes it word-by-word into instruction memory, then releases core reset and pulses `start`.
- Sits between a host byte interface (UART receiver or testbench) and the core's `rstn`/`start` inputs plus the instruction-memory write port.
- Supports reload from the run state and reports malformed images.

Parameters:
- ADDR_W, 32, width of `imem_waddr`.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be 4-byte aligned.
- MAX_WORDS, 1024, largest accepted image length in words.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- load_req  input  1  single-cycle request to begin (or restart) a load
- rx_valid  input  1  byte available on `rx_data`
- rx_data  input  8  incoming byte
- rx_ready  output  1  loader accepts `rx_data` this cycle
- imem_we  output  1  instruction-memory write strobe (full word)
- imem_waddr  output  ADDR_W  byte address of the write
- imem_wdata  output  32  write data
- core_rstn  output  1  active-low reset to the core (synchronous to clk)
- start  output  1  one-cycle start pulse to the core
- busy  output  1  high in HDR, DATA, WRITE, REL, START
- done  output  1  high in RUN
- err  output  1  high in ERR

Behaviour:
- Reset is asynchronous, active-low (`rstn`); clock is `clk`. Under reset, all of the following are 0: state IDLE, `rx_ready`, `imem_we`, `imem_waddr`, `imem_wdata`, `core_rstn`, `start`, `busy`, `done`, `err`, and all counters.
- Byte handshake:
  - A byte is consumed on a rising edge where `rx_valid` && `rx_ready`.
  - `rx_ready` is a registered/state-decoded output: 1 only in HDR and DATA.
  - `rx_data` is ignored otherwise.
- Image format:
  - 4-byte header giving length L in words, little-endian (first byte -> L[7:0]).
  - Followed by L*4 payload bytes, each word little-endian (first byte -> bits 7:0).
- States:
  - IDLE: `core_rstn`=0. On `load_req` -> HDR, clearing the byte counter, word index and length.
  - HDR: accept 4 bytes into L. On acceptance of the 4th byte:
    - if L==0 or L>MAX_WORDS -> ERR;
    - else -> DATA.
  - DATA: accept bytes into a word shift buffer, with a 2-bit byte counter. On acceptance of the 4th byte of a word -> WRITE.
  - WRITE (exactly 1 cycle):
    - `imem_we`=1, `imem_wdata`=assembled word, `imem_waddr`=BASE_ADDR + 4*word_idx (mod 2^ADDR_W), `rx_ready`=0.
    - word_idx increments.
    - If word_idx was L-1 -> REL; else -> DATA.
  - REL (1 cycle): `core_rstn`=1.
  - START (1 cycle): `core_rstn`=1, `start`=1 -> RUN.
  - RUN: `core_rstn`=1, `done`=1. On `load_req` -> HDR with `core_rstn` driven 0 again in HDR (core is re-held in reset during reload).
  - ERR: `core_rstn`=0, `err`=1. On `load_req` -> HDR; `err` clears on leaving ERR.
- Core reset rule: `core_rstn` is 1 only in REL, START and RUN.
- Output timing:
  - `imem_we` is 1 only in WRITE; `imem_waddr`/`imem_wdata` hold their last values otherwise.
  - `start` is high for exactly one cycle per successful load.
- Latency: last payload byte accepted at edge N -> WRITE during cycle N+1 -> REL N+2 -> START pulse N+3 -> `done` from N+4.
- Boundary conditions:
  - `load_req` is ignored in HDR, DATA, WRITE, REL and START; no abort mid-load.
  - A `load_req` coincident with a byte in IDLE/RUN/ERR: the state change wins and the byte is not consumed (`rx_ready` was 0).
  - Gaps with `rx_valid`=0 are arbitrary length; no timeout.
  - L==MAX_WORDS is accepted.
  - Asserting `rstn` low mid-load returns to IDLE immediately; memory contents already written are not undone.

Test Plan:
- Load L=2 (bytes 02 00 00 00, 13 05 10 00, 6F 00 00 00) with `rx_valid` held high -> writes 0x00100513 @0x0 then 0x0000006F @0x4; `start` pulse 3 cycles after last byte; `core_rstn` rises 1 cycle before `start`; `done`=1 thereafter.
- Header L=0 and, separately, L=MAX_WORDS+1 (01 04 00 00 for default) -> ERR, `err`=1, no `imem_we`, `core_rstn`=0; subsequent `load_req` + valid L=1 image recovers with `err`=0.
- Random `rx_valid` gaps (0-5 idle cycles between bytes), L=4 -> identical write sequence/addresses as the gapless case; `rx_ready` is 0 in every WRITE cycle.
- From RUN, `load_req` plus L=1 image 0xDEADBEEF -> `core_rstn` drops to 0 while the header is being received, single write 0xDEADBEEF @BASE_ADDR, second `start` pulse.
- `rstn` asserted after 6 payload bytes of an L=3 image -> all outputs 0 asynchronously; after release the loader stays in IDLE and ignores `rx_valid` until `load_req`.
- BASE_ADDR=32'h0000_1000, L=MAX_WORDS=4 -> addresses 0x1000/0x1004/0x1008/0x100C; L==MAX_WORDS accepted without error.
